// File: rtl/dmem_line_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_line_ctrl_if
//
// Purpose: bundles the cache-side request/response signals and the data-memory
// port of dmem_line_ctrl. Signal suffixes (_i/_o) are named from the
// controller's point of view.
//
// Modports:
//   master : the line controller (drives memory address/data/strobe, request
//            ready, completion pulse and refilled line).
//   slave  : the environment (cache issuing requests, memory returning data).
//
// Signals:
//   req_valid_i / req_ready_o   request handshake
//   req_wb_i / req_fill_i       request contains writeback / refill
//   wb_addr_i / fill_addr_i     line addresses (offset bits ignored)
//   wb_line_i                   line to write back, word i at [DW*i +: DW]
//   done_o                      one-cycle completion pulse
//   fill_line_o                 refilled line, same packing
//   mem_addr_o                  byte address to data memory
//   mem_write_data_o            store data
//   mem_write_en_o              store strobe
//   mem_funct3_o                access size (word)
//   mem_read_data_i             combinational read data for mem_addr_o
// -----------------------------------------------------------------------------
interface dmem_line_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
);

  logic                                 req_valid_i;
  logic                                 req_ready_o;
  logic                                 req_wb_i;
  logic                                 req_fill_i;
  logic [DATA_WIDTH-1:0]                wb_addr_i;
  logic [DATA_WIDTH-1:0]                fill_addr_i;
  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] wb_line_i;
  logic                                 done_o;
  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] fill_line_o;
  logic [DATA_WIDTH-1:0]                mem_addr_o;
  logic [DATA_WIDTH-1:0]                mem_write_data_o;
  logic                                 mem_write_en_o;
  logic [2:0]                           mem_funct3_o;
  logic [DATA_WIDTH-1:0]                mem_read_data_i;

  modport master (
    input  req_valid_i,
    output req_ready_o,
    input  req_wb_i,
    input  req_fill_i,
    input  wb_addr_i,
    input  fill_addr_i,
    input  wb_line_i,
    output done_o,
    output fill_line_o,
    output mem_addr_o,
    output mem_write_data_o,
    output mem_write_en_o,
    output mem_funct3_o,
    input  mem_read_data_i
  );

  modport slave (
    output req_valid_i,
    input  req_ready_o,
    output req_wb_i,
    output req_fill_i,
    output wb_addr_i,
    output fill_addr_i,
    output wb_line_i,
    input  done_o,
    input  fill_line_o,
    input  mem_addr_o,
    input  mem_write_data_o,
    input  mem_write_en_o,
    input  mem_funct3_o,
    output mem_read_data_i
  );

endinterface

// File: rtl/dmem_line_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_line_ctrl
//
// Purpose: line-transfer initiator between the data cache and the
// byte-addressable data memory. One request at a time is accepted in IDLE; it
// may write back a dirty line, refill a missing line, or both (writeback
// first). Each line is moved as back-to-back word accesses (funct3 = 3'b010),
// one word per clock, and a one-cycle done pulse marks completion.
//
// Parameters:
//   DATA_WIDTH      word width and memory address width
//   WORDS_PER_LINE  words per line, power of two >= 2
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dmem_line_ctrl_if.master: request handshake, writeback line,
//          refilled line, completion pulse and the memory port
//
// Sequencing: IDLE -> [WB x WORDS_PER_LINE] -> [FILL x WORDS_PER_LINE] -> DONE
// -> IDLE. Memory strobe, address and store data are decoded from the state and
// word-counter flops only, so an asynchronous reset drops the strobe at once.
// -----------------------------------------------------------------------------
module dmem_line_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_line_ctrl_if.master bus
);

  localparam int CNT_W  = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = $clog2(4 * WORDS_PER_LINE);
  localparam int LINE_W = DATA_WIDTH * WORDS_PER_LINE;

  localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(WORDS_PER_LINE - 1);
  // Clears the byte-within-line offset so every transfer starts on a line.
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [DATA_WIDTH-1:0] wb_base_q,   wb_base_d;
  logic [DATA_WIDTH-1:0] fill_base_q, fill_base_d;
  logic [LINE_W-1:0]     wb_line_q,   wb_line_d;
  logic                  do_fill_q,   do_fill_d;
  logic [LINE_W-1:0]     fill_line_q, fill_line_d;

  // The writeback flag only steers the IDLE exit, so it is never stored;
  // the fill flag is needed again when WB finishes.

  logic                  fill_capture;
  logic [DATA_WIDTH-1:0] word_offset;
  logic [DATA_WIDTH-1:0] wb_word [WORDS_PER_LINE];

  assign fill_capture = (state_q == S_FILL);

  // Byte offset of the current word inside the line (4 bytes per word).
  assign word_offset = {{(DATA_WIDTH-CNT_W-2){1'b0}}, cnt_q, 2'b00};

  // ---------------------------------------------------------------------------
  // Per-word views: unpack the latched writeback line and merge the word being
  // read this cycle into the refill line.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_words
    assign wb_word[gi] = wb_line_q[gi*DATA_WIDTH +: DATA_WIDTH];

    assign fill_line_d[gi*DATA_WIDTH +: DATA_WIDTH] =
      (fill_capture && (cnt_q == CNT_W'(gi))) ? bus.mem_read_data_i
                                              : fill_line_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wb_base_d   = wb_base_q;
    fill_base_d = fill_base_q;
    wb_line_d   = wb_line_q;
    do_fill_d   = do_fill_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          wb_base_d   = bus.wb_addr_i & ALIGN_MASK;
          fill_base_d = bus.fill_addr_i & ALIGN_MASK;
          wb_line_d   = bus.wb_line_i;
          do_fill_d   = bus.req_fill_i;
          cnt_d       = '0;
          if (bus.req_wb_i) begin
            state_d = S_WB;
          end else if (bus.req_fill_i) begin
            state_d = S_FILL;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_WB: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = do_fill_q ? S_FILL : S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FILL: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wb_base_q   <= '0;
      fill_base_q <= '0;
      wb_line_q   <= '0;
      do_fill_q   <= 1'b0;
      fill_line_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_base_q   <= wb_base_d;
      fill_base_q <= fill_base_d;
      wb_line_q   <= wb_line_d;
      do_fill_q   <= do_fill_d;
      fill_line_q <= fill_line_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from flops only
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready_o      = (state_q == S_IDLE);
    bus.done_o           = (state_q == S_DONE);
    bus.mem_write_en_o   = (state_q == S_WB);
    bus.mem_funct3_o     = 3'b010;
    bus.fill_line_o      = fill_line_q;
    bus.mem_addr_o       = '0;
    bus.mem_write_data_o = '0;

    case (state_q)
      S_WB: begin
        bus.mem_addr_o       = wb_base_q + word_offset;
        bus.mem_write_data_o = wb_word[cnt_q];
      end
      S_FILL: begin
        bus.mem_addr_o = fill_base_q + word_offset;
      end
      default: begin
        bus.mem_addr_o       = '0;
        bus.mem_write_data_o = '0;
      end
    endcase
  end

endmodule
